// File: rtl/mean_square_acc_pkg.sv
// Shared types and sizing helpers for the mean-square producer.
package mean_square_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQUARE = 2'd1,
        ACCUM  = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Sum of 2^window_log2 squares of inout_width-bit magnitudes never exceeds this width.
    function automatic int acc_width(input int inout_width, input int window_log2);
        return 2 * inout_width + window_log2;
    endfunction

endpackage

// File: rtl/mean_square_acc_if.sv
// Sample-in / mean-square-out bundle; radicand side matches the sqrt stage inputs.
interface mean_square_acc_if #(
    parameter int inout_width = 16
);
    logic signed [inout_width-1:0]   sample;
    logic                            i_data_valid;
    logic        [2*inout_width-1:0] radicand;
    logic                            o_data_valid;
    logic                            busy;
    logic                            error_overrun;

    modport master (
        output sample, i_data_valid,
        input  radicand, o_data_valid, busy, error_overrun
    );

    modport slave (
        input  sample, i_data_valid,
        output radicand, o_data_valid, busy, error_overrun
    );
endinterface

// File: rtl/mean_square_acc_seq_square.sv
// Sequential shift-add squarer: W partial products, one per cycle, starting on the start edge.
module seq_square #(
    parameter int W = 16
) (
    input  logic           aclk,
    input  logic           resetn,
    input  logic           start,
    input  logic [W-1:0]   operand,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;

    // The first partial product is folded into the start edge so done lands in the last busy cycle.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (cnt_q == '0) begin
            if (start) begin
                prod_d   = operand[0] ? {{W{1'b0}}, operand} : '0;
                mcand_d  = {{W{1'b0}}, operand} << 1;
                mplier_d = operand >> 1;
                cnt_d    = CW'(W - 1);
                done_d   = (W == 1);
            end
        end else begin
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            done_d   = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign done    = done_q;
    assign product = prod_q;
endmodule

// File: rtl/mean_square_acc.sv
// Squares incoming signed samples and emits the truncated mean over 2^window_log2 of them.
module mean_square_acc
    import mean_square_pkg::*;
#(
    parameter int inout_width = 16,
    parameter int window_log2 = 8
) (
    input  logic             aclk,
    input  logic             resetn,
    mean_square_acc_if.slave bus
);
    localparam int W  = inout_width;
    localparam int AW = acc_width(inout_width, window_log2);

    state_e                 state_q, state_d;
    logic [window_log2-1:0] cnt_q, cnt_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [2*W-1:0]         radicand_q, radicand_d;
    logic                   ovalid_q, ovalid_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;

    logic                   sq_start;
    logic [W-1:0]           sq_mag;
    logic                   sq_done;
    logic [2*W-1:0]         sq_product;

    // Two's-complement negate is exact for -2^(W-1) once read back as unsigned.
    assign sq_mag = bus.sample[W-1] ? (~bus.sample + 1'b1) : bus.sample;

    seq_square #(.W(W)) u_square (
        .aclk    (aclk),
        .resetn  (resetn),
        .start   (sq_start),
        .operand (sq_mag),
        .done    (sq_done),
        .product (sq_product)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        radicand_d = radicand_q;
        ovalid_d   = 1'b0;
        sq_start   = 1'b0;
        overrun_d  = bus.i_data_valid && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.i_data_valid) begin
                    sq_start = 1'b1;
                    state_d  = SQUARE;
                end
            end
            SQUARE: begin
                if (sq_done) state_d = ACCUM;
            end
            ACCUM: begin
                acc_d = acc_q + AW'(sq_product);
                if (cnt_q == {window_log2{1'b1}}) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                radicand_d = acc_q[window_log2 +: 2*W];
                ovalid_d   = 1'b1;
                acc_d      = '0;
                cnt_d      = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            radicand_q <= '0;
            ovalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            radicand_q <= radicand_d;
            ovalid_q   <= ovalid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.radicand      = radicand_q;
    assign bus.o_data_valid  = ovalid_q;
    assign bus.busy          = busy_q;
    assign bus.error_overrun = overrun_q;
endmodule
